lc3_control_store: RTL and testbench

Microcode state register and control store for the LC-3 control unit. It sits directly downstream of `microsequencer`: it registers the 6-bit next-state address that `microsequencer` produces, then looks up the 64-entry microinstruction ROM. It drives the microinstruction's sequencing fields (`ird`, `cond`, `j`) back into `microsequencer` and the datapath control bundle out to the LC-3 datapath. It also keeps a sticky illegal-state flag and an instruction-decode counter for debug.

---
 rtl/lc3_uc_pkg.sv | 115 +++++++++++
 rtl/lc3_uc_rom.sv | 162 ++++++++++++++++
 rtl/lc3_control_store.sv | 67 ++++++
 tb/tb_lc3_control_store.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_uc_pkg.sv
// LC-3 microcode definitions: control bundle layout, COND encodings, state map,
// microinstruction packing and the mask of populated ROM addresses.
package lc3_uc_pkg;

   localparam int unsigned STATE_W = 6;
   localparam int unsigned COND_W  = 3;
   localparam int unsigned J_W     = 6;
   localparam int unsigned CTRL_W  = 25;
   localparam int unsigned UWORD_W = 1 + COND_W + J_W + CTRL_W;

   // COND field; each condition ORs one J bit in the microsequencer
   localparam logic [COND_W-1:0] COND_UNC  = 3'b000;
   localparam logic [COND_W-1:0] COND_R    = 3'b001;  // bit1
   localparam logic [COND_W-1:0] COND_IR11 = 3'b010;  // bit2
   localparam logic [COND_W-1:0] COND_INT  = 3'b011;  // bit0
   localparam logic [COND_W-1:0] COND_BEN  = 3'b100;  // bit3
   localparam logic [COND_W-1:0] COND_PSR  = 3'b101;  // bit4

   localparam logic [1:0] PCMUX_INC   = 2'b00;
   localparam logic [1:0] PCMUX_BUS   = 2'b01;
   localparam logic [1:0] PCMUX_ADDER = 2'b10;
   localparam logic [1:0] DRMUX_IR11  = 2'b00;
   localparam logic [1:0] DRMUX_R7    = 2'b01;
   localparam logic [1:0] SR1MUX_IR11 = 2'b00;
   localparam logic [1:0] SR1MUX_IR8  = 2'b01;
   localparam logic       ADDR1_PC    = 1'b0;
   localparam logic       ADDR1_BASER = 1'b1;
   localparam logic [1:0] ADDR2_ZERO  = 2'b00;
   localparam logic [1:0] ADDR2_OFF6  = 2'b01;
   localparam logic [1:0] ADDR2_OFF9  = 2'b10;
   localparam logic [1:0] ADDR2_OFF11 = 2'b11;
   localparam logic       MARMUX_ZEXT = 1'b0;
   localparam logic       MARMUX_ADD  = 1'b1;
   localparam logic [1:0] ALUK_ADD    = 2'b00;
   localparam logic [1:0] ALUK_AND    = 2'b01;
   localparam logic [1:0] ALUK_NOT    = 2'b10;
   localparam logic [1:0] ALUK_PASSA  = 2'b11;

   // Microstate map; 0..15 are the IRD decode targets (opcode number)
   localparam logic [STATE_W-1:0] S_BR        = 6'd0;
   localparam logic [STATE_W-1:0] S_ADD       = 6'd1;
   localparam logic [STATE_W-1:0] S_LD        = 6'd2;
   localparam logic [STATE_W-1:0] S_ST        = 6'd3;
   localparam logic [STATE_W-1:0] S_JSR       = 6'd4;
   localparam logic [STATE_W-1:0] S_AND       = 6'd5;
   localparam logic [STATE_W-1:0] S_LDR       = 6'd6;
   localparam logic [STATE_W-1:0] S_STR       = 6'd7;
   localparam logic [STATE_W-1:0] S_NOT       = 6'd9;
   localparam logic [STATE_W-1:0] S_LDI       = 6'd10;
   localparam logic [STATE_W-1:0] S_STI       = 6'd11;
   localparam logic [STATE_W-1:0] S_JMP       = 6'd12;
   localparam logic [STATE_W-1:0] S_LEA       = 6'd14;
   localparam logic [STATE_W-1:0] S_TRAP      = 6'd15;
   localparam logic [STATE_W-1:0] S_ST_WRITE  = 6'd16;
   localparam logic [STATE_W-1:0] S_FETCH1    = 6'd18;
   localparam logic [STATE_W-1:0] S_ST_MDR    = 6'd23;
   localparam logic [STATE_W-1:0] S_LD_READ   = 6'd25;
   localparam logic [STATE_W-1:0] S_BR_TAKEN  = 6'd26;
   localparam logic [STATE_W-1:0] S_LD_WB     = 6'd27;
   localparam logic [STATE_W-1:0] S_TRAP_READ = 6'd28;
   localparam logic [STATE_W-1:0] S_STI_READ  = 6'd29;
   localparam logic [STATE_W-1:0] S_TRAP_PC   = 6'd30;
   localparam logic [STATE_W-1:0] S_STI_MAR   = 6'd31;
   localparam logic [STATE_W-1:0] S_DECODE    = 6'd32;
   localparam logic [STATE_W-1:0] S_FETCH2    = 6'd33;
   localparam logic [STATE_W-1:0] S_FETCH3    = 6'd35;
   localparam logic [STATE_W-1:0] S_LDI_READ  = 6'd36;
   localparam logic [STATE_W-1:0] S_LDI_MAR   = 6'd38;
   localparam logic [STATE_W-1:0] S_JSRR      = 6'd40;
   localparam logic [STATE_W-1:0] S_JSR_OFF   = 6'd44;

   // One bit per populated address above; RTI (8) and reserved (13) are absent
   localparam logic [63:0] VALID_MASK = 64'h0000_115B_FE85_DEFF;

   typedef struct packed {
      logic       ld_mar;
      logic       ld_mdr;
      logic       ld_ir;
      logic       ld_ben;
      logic       ld_reg;
      logic       ld_cc;
      logic       ld_pc;
      logic       gate_pc;
      logic       gate_mdr;
      logic       gate_alu;
      logic       gate_marmux;
      logic [1:0] pcmux;
      logic [1:0] drmux;
      logic [1:0] sr1mux;
      logic       addr1mux;
      logic [1:0] addr2mux;
      logic       marmux;
      logic [1:0] aluk;
      logic       mio_en;
      logic       r_w;
   } uc_ctrl_t;

   typedef struct packed {
      logic              ird;
      logic [COND_W-1:0] cond;
      logic [J_W-1:0]    j;
      uc_ctrl_t          ctrl;
   } uc_word_t;

   function automatic uc_word_t uc_pack(input logic ird, input logic [COND_W-1:0] cond,
                                        input logic [J_W-1:0] j, input uc_ctrl_t ctrl);
      uc_word_t w;
      w.ird  = ird;
      w.cond = cond;
      w.j    = j;
      w.ctrl = ctrl;
      return w;
   endfunction

endpackage

// File: rtl/lc3_uc_rom.sv
// Combinational 64-entry LC-3 user-mode microinstruction ROM (IRD, COND, J, ctrl).
module lc3_uc_rom
   import lc3_uc_pkg::*;
(
   input  logic [STATE_W-1:0] state,
   output uc_word_t           word
);

   uc_ctrl_t          c;
   logic              ird;
   logic [COND_W-1:0] cond;
   logic [J_W-1:0]    j;

   // Unpopulated addresses fall through to an all-zero word with J=FETCH1
   always_comb begin
      c    = '0;
      ird  = 1'b0;
      cond = COND_UNC;
      j    = S_FETCH1;
      case (state)
         S_FETCH1: begin
            c.ld_mar  = 1'b1;
            c.gate_pc = 1'b1;
            c.ld_pc   = 1'b1;
            c.pcmux   = PCMUX_INC;
            j         = S_FETCH2;
         end
         S_FETCH2: begin
            c.ld_mdr = 1'b1;
            c.mio_en = 1'b1;
            cond     = COND_R;
            j        = S_FETCH2;
         end
         S_FETCH3: begin
            c.ld_ir    = 1'b1;
            c.gate_mdr = 1'b1;
            j          = S_DECODE;
         end
         S_DECODE: begin
            c.ld_ben = 1'b1;
            ird      = 1'b1;
            j        = S_BR;
         end
         S_BR: begin
            cond = COND_BEN;
            j    = S_FETCH1;
         end
         S_BR_TAKEN, S_JSR_OFF: begin
            c.ld_pc    = 1'b1;
            c.pcmux    = PCMUX_ADDER;
            c.addr1mux = ADDR1_PC;
            c.addr2mux = (state == S_JSR_OFF) ? ADDR2_OFF11 : ADDR2_OFF9;
         end
         S_ADD, S_AND, S_NOT: begin
            c.ld_reg   = 1'b1;
            c.ld_cc    = 1'b1;
            c.gate_alu = 1'b1;
            c.drmux    = DRMUX_IR11;
            c.sr1mux   = SR1MUX_IR8;
            c.aluk     = (state == S_AND) ? ALUK_AND :
                         (state == S_NOT) ? ALUK_NOT : ALUK_ADD;
         end
         S_LD, S_LDI, S_ST, S_STI: begin
            c.ld_mar      = 1'b1;
            c.gate_marmux = 1'b1;
            c.marmux      = MARMUX_ADD;
            c.addr1mux    = ADDR1_PC;
            c.addr2mux    = ADDR2_OFF9;
            j = (state == S_LD)  ? S_LD_READ  :
                (state == S_LDI) ? S_LDI_READ :
                (state == S_ST)  ? S_ST_MDR   : S_STI_READ;
         end
         S_LDR, S_STR: begin
            c.ld_mar      = 1'b1;
            c.gate_marmux = 1'b1;
            c.marmux      = MARMUX_ADD;
            c.addr1mux    = ADDR1_BASER;
            c.addr2mux    = ADDR2_OFF6;
            c.sr1mux      = SR1MUX_IR8;
            j = (state == S_LDR) ? S_LD_READ : S_ST_MDR;
         end
         S_LEA: begin
            c.ld_reg      = 1'b1;
            c.ld_cc       = 1'b1;
            c.gate_marmux = 1'b1;
            c.marmux      = MARMUX_ADD;
            c.addr1mux    = ADDR1_PC;
            c.addr2mux    = ADDR2_OFF9;
            c.drmux       = DRMUX_IR11;
         end
         S_JMP, S_JSRR: begin
            c.ld_pc    = 1'b1;
            c.pcmux    = PCMUX_ADDER;
            c.addr1mux = ADDR1_BASER;
            c.addr2mux = ADDR2_ZERO;
            c.sr1mux   = SR1MUX_IR8;
         end
         // R7 is written before the target is formed; IR[11] picks offset vs base
         S_JSR: begin
            c.ld_reg  = 1'b1;
            c.drmux   = DRMUX_R7;
            c.gate_pc = 1'b1;
            cond      = COND_IR11;
            j         = S_JSRR;
         end
         S_TRAP: begin
            c.ld_mar      = 1'b1;
            c.gate_marmux = 1'b1;
            c.marmux      = MARMUX_ZEXT;
            j             = S_TRAP_READ;
         end
         S_TRAP_READ: begin
            c.ld_mdr  = 1'b1;
            c.mio_en  = 1'b1;
            c.ld_reg  = 1'b1;
            c.drmux   = DRMUX_R7;
            c.gate_pc = 1'b1;
            cond      = COND_R;
            j         = S_TRAP_READ;
         end
         S_TRAP_PC: begin
            c.gate_mdr = 1'b1;
            c.ld_pc    = 1'b1;
            c.pcmux    = PCMUX_BUS;
         end
         S_LD_READ, S_LDI_READ, S_STI_READ: begin
            c.ld_mdr = 1'b1;
            c.mio_en = 1'b1;
            cond     = COND_R;
            j        = state;
         end
         S_LD_WB: begin
            c.gate_mdr = 1'b1;
            c.ld_reg   = 1'b1;
            c.ld_cc    = 1'b1;
            c.drmux    = DRMUX_IR11;
         end
         S_LDI_MAR, S_STI_MAR: begin
            c.gate_mdr = 1'b1;
            c.ld_mar   = 1'b1;
            j = (state == S_LDI_MAR) ? S_LD_READ : S_ST_MDR;
         end
         S_ST_MDR: begin
            c.ld_mdr   = 1'b1;
            c.gate_alu = 1'b1;
            c.aluk     = ALUK_PASSA;
            c.sr1mux   = SR1MUX_IR11;
            j          = S_ST_WRITE;
         end
         // 16 | R-bit lands on FETCH1 once the write completes
         S_ST_WRITE: begin
            c.mio_en = 1'b1;
            c.r_w    = 1'b1;
            cond     = COND_R;
            j        = S_ST_WRITE;
         end
         default: ;
      endcase
      word = uc_pack(ird, cond, j, c);
   end

endmodule

// File: rtl/lc3_control_store.sv
// LC-3 microstate register with control-store lookup, illegal-state recovery
// and decode counter.
module lc3_control_store
   import lc3_uc_pkg::*;
#(
   parameter logic [STATE_W-1:0] RESET_STATE = 6'd18,
   parameter int unsigned        CNT_W       = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ce,
   input  logic [STATE_W-1:0] next_state,
   output logic [STATE_W-1:0] state,
   output logic               ird,
   output logic [COND_W-1:0]  cond,
   output logic [J_W-1:0]     j,
   output uc_ctrl_t           ctrl,
   output logic               bad_state,
   output logic [CNT_W-1:0]   instr_count
);

   logic [STATE_W-1:0] state_nxt;
   logic               bad_nxt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               load_ok;
   uc_word_t           word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RESET_STATE;
         bad_state   <= 1'b0;
         instr_count <= '0;
      end else begin
         state       <= state_nxt;
         bad_state   <= bad_nxt;
         instr_count <= cnt_nxt;
      end
   end

   // Unpopulated targets restart at FETCH1; the decode count is independent
   always_comb begin
      state_nxt = state;
      bad_nxt   = bad_state;
      cnt_nxt   = instr_count;
      load_ok   = VALID_MASK[next_state];
      if (ce) begin
         state_nxt = load_ok ? next_state : RESET_STATE;
         bad_nxt   = bad_state | ~load_ok;
         if (state == S_DECODE) begin
            cnt_nxt = instr_count + CNT_W'(1);
         end
      end
   end

   lc3_uc_rom u_rom (
      .state (state),
      .word  (word)
   );

   always_comb begin
      ird  = word.ird;
      cond = word.cond;
      j    = word.j;
      ctrl = word.ctrl;
   end

endmodule

// File: tb/tb_lc3_control_store.sv
// Bench for lc3_control_store: closes the loop through a behavioural
// microsequencer and scores the state trajectory against expected tables.
module tb_lc3_control_store;
   import lc3_uc_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n, ce, use_seq, r, ben, ir11, ce_w;
   logic [3:0] op;
   logic [5:0] ns_drive, next_state, ns_w;
   logic [5:0] state, j, state_w, j_w;
   logic       ird, bad_state, ird_w, bad_w;
   logic [2:0] cond, cond_w;
   uc_ctrl_t   ctrl, ctrl_w;
   logic [15:0] instr_count;
   logic [3:0]  cnt_w;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;
   logic [5:0] sb[$];
   logic [3:0] sbc[$];

   int op_tbl  [15] = '{1, 5, 9, 2, 6, 10, 14, 3, 7, 11, 4, 4, 12, 15, 0};
   int i11_tbl [15] = '{0, 0, 0, 0, 0, 0,  0,  0, 0, 0,  1, 0, 0,  0,  0};
   int ben_tbl [15] = '{0, 0, 0, 0, 0, 0,  0,  0, 0, 0,  0, 0, 0,  0,  1};
   int seq_tbl [15][9] = '{
      '{33, 35, 32,  1, 18, 18, 18, 18, 18},
      '{33, 35, 32,  5, 18, 18, 18, 18, 18},
      '{33, 35, 32,  9, 18, 18, 18, 18, 18},
      '{33, 35, 32,  2, 25, 27, 18, 18, 18},
      '{33, 35, 32,  6, 25, 27, 18, 18, 18},
      '{33, 35, 32, 10, 36, 38, 25, 27, 18},
      '{33, 35, 32, 14, 18, 18, 18, 18, 18},
      '{33, 35, 32,  3, 23, 16, 18, 18, 18},
      '{33, 35, 32,  7, 23, 16, 18, 18, 18},
      '{33, 35, 32, 11, 29, 31, 23, 16, 18},
      '{33, 35, 32,  4, 44, 18, 18, 18, 18},
      '{33, 35, 32,  4, 40, 18, 18, 18, 18},
      '{33, 35, 32, 12, 18, 18, 18, 18, 18},
      '{33, 35, 32, 15, 28, 30, 18, 18, 18},
      '{33, 35, 32,  0, 26, 18, 18, 18, 18}};

   always #5 clk = ~clk;

   // Behavioural microsequencer: IRD decodes opcode, else J | condition bit
   function automatic logic [5:0] useq(input logic i_ird, input logic [2:0] c,
                                       input logic [5:0] jj, input logic rr,
                                       input logic bb, input logic i11,
                                       input logic [3:0] opc);
      logic [5:0] m;
      logic [5:0] res;
      case (c)
         3'b001:  m = {4'b0, rr, 1'b0};
         3'b010:  m = {3'b0, i11, 2'b0};
         3'b100:  m = {2'b0, bb, 3'b0};
         default: m = 6'd0;
      endcase
      res = i_ird ? {2'b00, opc} : (jj | m);
      return res;
   endfunction

   always_comb next_state = use_seq ? useq(ird, cond, j, r, ben, ir11, op) : ns_drive;

   lc3_control_store u_dut (
      .clk (clk), .rst_n (rst_n), .ce (ce), .next_state (next_state),
      .state (state), .ird (ird), .cond (cond), .j (j), .ctrl (ctrl),
      .bad_state (bad_state), .instr_count (instr_count));

   lc3_control_store #(.CNT_W(4)) u_wrap (
      .clk (clk), .rst_n (rst_n), .ce (ce_w), .next_state (ns_w),
      .state (state_w), .ird (ird_w), .cond (cond_w), .j (j_w), .ctrl (ctrl_w),
      .bad_state (bad_w), .instr_count (cnt_w));

   task automatic test_reset();
      logic [5:0] e;
      rst_n = 1'b0; ce = 1'b1; use_seq = 1'b0; ns_drive = 6'd33;
      r = 1'b0; ben = 1'b0; ir11 = 1'b0; op = 4'd0; ce_w = 1'b0; ns_w = 6'd32;
      repeat (2) @(negedge clk);
      checks++; if (state !== 6'd18) begin errors++; $display("FAIL reset_state got %0d exp 18", state); end
      checks++; if (j !== 6'd33) begin errors++; $display("FAIL reset_j got %0d exp 33", j); end
      checks++; if (ctrl !== 25'h1060000) begin errors++; $display("FAIL reset_ctrl got %h exp 1060000", ctrl); end
      checks++; if ({ird, cond} !== 4'b0000) begin errors++; $display("FAIL reset_ird_cond got %b exp 0000", {ird, cond}); end
      checks++; if (instr_count !== 16'h0) begin errors++; $display("FAIL reset_count got %h exp 0000", instr_count); end
      checks++; if (bad_state !== 1'b0) begin errors++; $display("FAIL reset_bad got %b exp 0", bad_state); end
      rst_n = 1'b1;
      sb.push_back(6'd33);
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      checks++; if (state !== e) begin errors++; $display("FAIL first_load state got %0d exp %0d", state, e); end
      checks++; if (ctrl !== 25'h0800002) begin errors++; $display("FAIL fetch2_ctrl got %h exp 0800002", ctrl); end
      checks++; if (cond !== 3'b001) begin errors++; $display("FAIL fetch2_cond got %b exp 001", cond); end
      exp_cnt = 0;
   endtask

   task automatic test_fetch();
      logic [5:0] e;
      use_seq = 1'b1; r = 1'b0; ben = 1'b0; op = 4'd0;
      for (int i = 0; i < 5; i++) begin
         r = (i >= 3);
         sb.push_back(i < 3 ? 6'd33 : (i == 3 ? 6'd35 : 6'd32));
         @(posedge clk); @(negedge clk);
         e = sb.pop_front();
         checks++; if (state !== e) begin errors++; $display("FAIL fetch step %0d state got %0d exp %0d", i, state, e); end
      end
      checks++; if (ird !== 1'b1) begin errors++; $display("FAIL decode_ird got %b exp 1", ird); end
      checks++; if (ctrl !== 25'h0200000) begin errors++; $display("FAIL decode_ctrl got %h exp 0200000", ctrl); end
      sb.push_back(6'd0);
      @(posedge clk); @(negedge clk);
      e = sb.pop_front(); exp_cnt++;
      checks++; if (state !== e) begin errors++; $display("FAIL decode_br state got %0d exp %0d", state, e); end
      checks++; if ({cond, j} !== {3'b100, 6'd18}) begin errors++; $display("FAIL br_cond_j got %b/%0d exp 100/18", cond, j); end
   endtask

   task automatic test_branch();
      logic [5:0] e;
      logic [5:0] exp_s [7] = '{6'd26, 6'd18, 6'd33, 6'd35, 6'd32, 6'd0, 6'd18};
      for (int i = 0; i < 7; i++) begin
         ben = (i == 0); r = 1'b1;
         sb.push_back(exp_s[i]);
         @(posedge clk); @(negedge clk);
         e = sb.pop_front();
         checks++; if (state !== e) begin errors++; $display("FAIL branch step %0d state got %0d exp %0d", i, state, e); end
         if (i == 0) begin
            checks++; if (ctrl !== 25'h0042040) begin errors++; $display("FAIL br_taken_ctrl got %h exp 0042040", ctrl); end
         end
         if (i == 1) begin
            checks++; if (instr_count !== 16'(exp_cnt)) begin errors++; $display("FAIL count_one_br got %0d exp %0d", instr_count, exp_cnt); end
         end
      end
      exp_cnt++;
      checks++; if (instr_count !== 16'(exp_cnt)) begin errors++; $display("FAIL count_two_br got %0d exp %0d", instr_count, exp_cnt); end
   endtask

   task automatic test_stall();
      logic [5:0] e;
      use_seq = 1'b0;
      for (int i = 0; i < 12; i++) begin
         ns_drive = (i == 0) ? 6'd33 : (i < 7) ? 6'd35 : (i < 11) ? 6'd32 : 6'd18;
         ce = !((i >= 1 && i <= 5) || (i >= 8 && i <= 10));
         sb.push_back((i < 6) ? 6'd33 : (i == 6) ? 6'd35 : (i < 11) ? 6'd32 : 6'd18);
         @(posedge clk); @(negedge clk);
         e = sb.pop_front();
         checks++; if (state !== e) begin errors++; $display("FAIL stall step %0d state got %0d exp %0d", i, state, e); end
         if (i == 5 || i == 10) begin
            checks++; if (instr_count !== 16'(exp_cnt)) begin errors++; $display("FAIL stall_count step %0d got %0d exp %0d", i, instr_count, exp_cnt); end
         end
         if (i == 5) begin
            checks++; if (cond !== 3'b001) begin errors++; $display("FAIL stall_cond got %b exp 001", cond); end
         end
      end
      exp_cnt++;
      checks++; if (instr_count !== 16'(exp_cnt)) begin errors++; $display("FAIL stall_resume_count got %0d exp %0d", instr_count, exp_cnt); end
      ce = 1'b1;
   endtask

   task automatic test_opcodes();
      logic [5:0] e;
      use_seq = 1'b1; r = 1'b1; ce = 1'b1;
      for (int k = 0; k < 15; k++) begin
         op = 4'(op_tbl[k]); ir11 = 1'(i11_tbl[k]); ben = 1'(ben_tbl[k]);
         for (int i = 0; i < 9; i++) begin
            sb.push_back(6'(seq_tbl[k][i]));
            @(posedge clk); @(negedge clk);
            e = sb.pop_front();
            checks++; if (state !== e) begin errors++; $display("FAIL op%0d step %0d state got %0d exp %0d", op_tbl[k], i, state, e); end
            if (e == 6'd16) begin
               checks++; if ({ctrl.mio_en, ctrl.r_w} !== 2'b11) begin errors++; $display("FAIL st_write_ctrl got %b exp 11", {ctrl.mio_en, ctrl.r_w}); end
            end
            if (e == 6'd30) begin
               checks++; if ({ctrl.gate_mdr, ctrl.pcmux} !== 3'b101) begin errors++; $display("FAIL trap_pc_ctrl got %b exp 101", {ctrl.gate_mdr, ctrl.pcmux}); end
            end
            if (e == 6'd18) break;
         end
         exp_cnt++;
      end
      checks++; if (instr_count !== 16'(exp_cnt)) begin errors++; $display("FAIL opcodes_count got %0d exp %0d", instr_count, exp_cnt); end
      checks++; if (bad_state !== 1'b0) begin errors++; $display("FAIL opcodes_bad got %b exp 0", bad_state); end
   endtask

   task automatic test_illegal();
      logic [5:0] e;
      logic [5:0] exp_s [13] = '{6'd33, 6'd18, 6'd33, 6'd35, 6'd32, 6'd18,
                                 6'd33, 6'd35, 6'd32, 6'd1, 6'd18, 6'd33, 6'd35};
      for (int i = 0; i < 13; i++) begin
         use_seq = (i >= 2); ns_drive = (i == 0) ? 6'd33 : 6'd50;
         r = 1'b1; op = (i < 6) ? 4'd13 : 4'd1;
         sb.push_back(exp_s[i]);
         @(posedge clk); @(negedge clk);
         e = sb.pop_front();
         checks++; if (state !== e) begin errors++; $display("FAIL illegal step %0d state got %0d exp %0d", i, state, e); end
         checks++; if (bad_state !== (i >= 1)) begin errors++; $display("FAIL illegal step %0d bad got %b exp %b", i, bad_state, (i >= 1)); end
         if (i == 5 || i == 10) begin
            exp_cnt++;
            checks++; if (instr_count !== 16'(exp_cnt)) begin errors++; $display("FAIL illegal_count step %0d got %0d exp %0d", i, instr_count, exp_cnt); end
         end
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({state, bad_state, instr_count} !== {6'd18, 1'b0, 16'h0}) begin
         errors++; $display("FAIL async_reset got %0d/%b/%0d exp 18/0/0", state, bad_state, instr_count); end
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;
   endtask

   task automatic test_wrap();
      logic [3:0] e;
      ce_w = 1'b1;
      for (int i = 1; i <= 18; i++) begin
         sbc.push_back(4'((i - 1) % 16));
         @(posedge clk); @(negedge clk);
         e = sbc.pop_front();
         checks++; if (cnt_w !== e) begin errors++; $display("FAIL wrap edge %0d count got %0d exp %0d", i, cnt_w, e); end
      end
      checks++; if ({state_w, ird_w, cond_w, j_w, bad_w} !== {6'd32, 1'b1, 3'b000, 6'd0, 1'b0}) begin
         errors++; $display("FAIL wrap_decode_word got %0d/%b/%b/%0d/%b", state_w, ird_w, cond_w, j_w, bad_w); end
      checks++; if (ctrl_w !== 25'h0200000) begin errors++; $display("FAIL wrap_ctrl got %h exp 0200000", ctrl_w); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_branch();
      test_stall();
      test_opcodes();
      test_illegal();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
